// File: rtl/performance_sequencer_if.sv
// Event RAM bus between the record/playback sequencer and its single-port RAM.
interface performance_sequencer_if #(
  parameter int unsigned NKEYS  = 28,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TIME_W = 20
);
  logic [ADDR_W-1:0]       mem_addr;
  logic [TIME_W+NKEYS-1:0] mem_wdata;
  logic                    mem_we;
  logic [TIME_W+NKEYS-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/performance_sequencer.sv
// Record/playback controller: timestamps key-vector changes into an event RAM while
// recording, and replays them to the note path at the recorded times during playback.
module performance_sequencer #(
  parameter int unsigned NKEYS  = 28,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TIME_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              mode,
  input  logic                    tick,
  input  logic [NKEYS-1:0]        keyState,
  performance_sequencer_if.master mem,
  output logic [NKEYS-1:0]        playKeys,
  output logic [ADDR_W:0]         eventCount,
  output logic                    recFull,
  output logic                    playDone
);

  // Pointer value meaning "RAM full" (2**ADDR_W).
  localparam logic [ADDR_W:0] DepthVal = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StRec,
    StPbFetch,
    StPbWait,
    StPbHold,
    StPbDone
  } seqState_t;

  seqState_t          state, stateNext;
  logic [TIME_W-1:0]  timeNow;
  logic [ADDR_W:0]    wrPtr;
  logic [ADDR_W:0]    rdPtr;
  logic [NKEYS-1:0]   lastKeys;
  logic [TIME_W-1:0]  evTime;
  logic [NKEYS-1:0]   evKeys;

  logic inPb;
  logic keyChange;
  logic goIdle;
  logic recEntry;
  logic pbEntry;
  logic doWrite;
  logic dropEvent;
  logic playEvent;

  assign inPb = (state == StPbFetch) || (state == StPbWait) ||
                (state == StPbHold)  || (state == StPbDone);
  assign keyChange = (keyState != lastKeys);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StIdle;
    end else begin
      state <= stateNext;
    end
  end

  // Mode decode overrides the per-state sequencing; entries take priority over normal flow.
  always_comb begin
    stateNext = state;
    goIdle    = 1'b0;
    recEntry  = 1'b0;
    pbEntry   = 1'b0;
    doWrite   = 1'b0;
    dropEvent = 1'b0;
    playEvent = 1'b0;
    if (mode == 3'd0 || mode >= 3'd4) begin
      goIdle    = 1'b1;
      stateNext = StIdle;
    end else if (mode == 3'd3 || (mode == 3'd2 && !inPb)) begin
      // Mode 3 holds the block in a freshly cleared fetch state.
      pbEntry   = 1'b1;
      stateNext = StPbFetch;
    end else if (mode == 3'd1 && state != StRec) begin
      recEntry  = 1'b1;
      stateNext = StRec;
    end else begin
      unique case (state)
        StRec: begin
          if (keyChange) begin
            if (wrPtr < DepthVal) doWrite = 1'b1;
            else                  dropEvent = 1'b1;
          end
        end
        StPbFetch: stateNext = (rdPtr == eventCount) ? StPbDone : StPbWait;
        StPbWait:  stateNext = StPbHold;
        StPbHold: begin
          if (timeNow >= evTime) begin
            playEvent = 1'b1;
            stateNext = StPbFetch;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM bus drive; address is the write pointer in REC and the read pointer when fetching.
  always_comb begin
    mem.mem_we    = doWrite && !reset;
    mem.mem_wdata = {timeNow, keyState};
    mem.mem_addr  = '0;
    if (!reset) begin
      if (state == StRec)          mem.mem_addr = wrPtr[ADDR_W-1:0];
      else if (state == StPbFetch) mem.mem_addr = rdPtr[ADDR_W-1:0];
    end
  end

  // Datapath registers: time base, pointers, captured event and replay outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeNow    <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      lastKeys   <= '0;
      evTime     <= '0;
      evKeys     <= '0;
      playKeys   <= '0;
      eventCount <= '0;
      recFull    <= 1'b0;
      playDone   <= 1'b0;
    end else begin
      // Entry clears below override this increment.
      if (tick && (timeNow != '1) && (state == StRec || inPb)) begin
        timeNow <= timeNow + 1'b1;
      end
      if (goIdle) begin
        playKeys <= '0;
        playDone <= 1'b0;
      end else if (recEntry) begin
        timeNow    <= '0;
        wrPtr      <= '0;
        lastKeys   <= '0;
        recFull    <= 1'b0;
        eventCount <= '0;
      end else if (pbEntry) begin
        timeNow  <= '0;
        rdPtr    <= '0;
        playKeys <= '0;
        playDone <= 1'b0;
      end else begin
        if (state == StRec) lastKeys <= keyState;
        if (doWrite) begin
          wrPtr      <= wrPtr + 1'b1;
          eventCount <= eventCount + 1'b1;
        end
        if (dropEvent) recFull <= 1'b1;
        if (state == StPbWait) begin
          evTime <= mem.mem_rdata[TIME_W+NKEYS-1:NKEYS];
          evKeys <= mem.mem_rdata[NKEYS-1:0];
        end
        if (playEvent) begin
          playKeys <= evKeys;
          rdPtr    <= rdPtr + 1'b1;
        end
        if (stateNext == StPbDone) begin
          playDone <= 1'b1;
          playKeys <= '0;
        end
      end
    end
  end

endmodule
